// File: rtl/wptr_gray_full_pkg.sv
// Shared async-FIFO pointer helpers: widths, depth and Gray/binary conversions.
// Functions work on a wide vector so any pointer width can zero-extend into them.
package fifo_pkg;

   localparam int unsigned FIFO_W = 4;
   localparam int unsigned DEPTH  = 1 << FIFO_W;
   localparam int unsigned GVEC_W = 32;

   typedef logic [FIFO_W:0]   ptr_t;
   typedef logic [FIFO_W-1:0] addr_t;
   typedef logic [GVEC_W-1:0] gvec_t;

   function automatic gvec_t bin2gray(input gvec_t b);
      return b ^ (b >> 1);
   endfunction

   // Bit i is the XOR of bits MSB..i; zero-extended upper bits leave the result unchanged.
   function automatic gvec_t gray2bin(input gvec_t g);
      gvec_t b;
      b[GVEC_W-1] = g[GVEC_W-1];
      for (int unsigned i = GVEC_W - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

endpackage

// File: rtl/wptr_gray_full_enc.sv
// Combinational binary-to-Gray encoder, shared by the write and read pointer blocks.
module bin2gray_enc #(
   parameter int unsigned N = 5
) (
   input  logic [N-1:0] bin,
   output logic [N-1:0] gray
);

   always_comb begin
      gray = bin ^ (bin >> 1);
   end

endmodule

// File: rtl/wptr_gray_full.sv
// Write-side pointer of the async FIFO: binary/Gray write pointer, full,
// almost-full, write-domain fill level and overflow pulse.
module wptr_gray_full
   import fifo_pkg::*;
#(
   parameter int unsigned W         = 4,
   parameter int unsigned AF_THRESH = 12
) (
   input  logic         wclk,
   input  logic         wrst_n,
   input  logic         winc,
   input  logic [W:0]   wq2_rgray,
   output logic [W-1:0] waddr,
   output logic [W:0]   wgray,
   output logic         wfull,
   output logic         walmost_full,
   output logic [W:0]   wlevel,
   output logic         wovf
);

   typedef logic [W:0] wptr_t;

   localparam wptr_t AF_LVL = wptr_t'(AF_THRESH);

   wptr_t wbin;
   wptr_t wbin_next;
   wptr_t wgray_next;
   wptr_t rgray_full;
   wptr_t rbin_s;
   wptr_t wlevel_next;
   logic  push;
   logic  wfull_next;
   logic  waf_next;
   logic  wovf_next;

   bin2gray_enc #(.N(W + 1)) u_enc (
      .bin  (wbin_next),
      .gray (wgray_next)
   );

   // Full when the write pointer is one full lap ahead: top two Gray bits inverted.
   always_comb begin
      push        = winc & ~wfull;
      wbin_next   = wbin + wptr_t'(push);
      rgray_full  = {~wq2_rgray[W:W-1], wq2_rgray[W-2:0]};
      rbin_s      = wptr_t'(gray2bin(gvec_t'(wq2_rgray)));
      wlevel_next = wbin_next - rbin_s;
      wfull_next  = (wgray_next == rgray_full);
      waf_next    = (wlevel_next >= AF_LVL);
      wovf_next   = winc & wfull;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin         <= '0;
         wgray        <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wgray        <= wgray_next;
         wfull        <= wfull_next;
         walmost_full <= waf_next;
         wlevel       <= wlevel_next;
         wovf         <= wovf_next;
      end
   end

   assign waddr = wbin[W-1:0];

endmodule

// File: tb/tb_wptr_gray_full.sv
// Self-checking bench for wptr_gray_full (W=4): expected outputs are queued
// when stimulus is driven and popped after the following clock edge.
module tb_wptr_gray_full;

   localparam int unsigned W = 4;

   typedef struct {
      logic [3:0] waddr;
      logic [4:0] wgray;
      logic       wfull;
      logic       waf;
      logic [4:0] wlevel;
      logic       wovf;
   } exp_t;

   logic       wclk = 1'b0;
   logic       wrst_n = 1'b0;
   logic       winc = 1'b0;
   logic [4:0] wq2_rgray = '0;
   logic [3:0] waddr;
   logic [4:0] wgray;
   logic       wfull;
   logic       walmost_full;
   logic [4:0] wlevel;
   logic       wovf;

   int unsigned tests = 0;
   int unsigned fails = 0;
   exp_t        q[$];
   logic [4:0]  mbin = '0;
   logic        mfull = 1'b0;

   wptr_gray_full #(.W(W), .AF_THRESH(12)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .wq2_rgray    (wq2_rgray),
      .waddr        (waddr),
      .wgray        (wgray),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   always #5 wclk = ~wclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one cycle; rb is the read pointer in binary, presented to the DUT in Gray.
   task automatic drive(input logic w, input logic [4:0] rb);
      exp_t       e;
      logic [4:0] nb;
      logic [4:0] lvl;
      logic       p;
      @(negedge wclk);
      winc      = w;
      wq2_rgray = rb ^ (rb >> 1);
      p         = w & ~mfull;
      nb        = mbin + {4'b0000, p};
      lvl       = nb - rb;
      e.waddr   = nb[3:0];
      e.wgray   = nb ^ (nb >> 1);
      e.wfull   = (lvl == 5'd16);
      e.waf     = (lvl >= 5'd12);
      e.wlevel  = lvl;
      e.wovf    = w & mfull;
      q.push_back(e);
      mbin  = nb;
      mfull = e.wfull;
      @(posedge wclk);
      #1;
   endtask

   task automatic apply_reset();
      wrst_n    = 1'b0;
      winc      = 1'b0;
      wq2_rgray = '0;
      mbin      = '0;
      mfull     = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      apply_reset();
      #12;
      tests++;
      if ({waddr, wgray, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
         fails++;
         $display("FAIL reset_state: got %h want 0", {waddr, wgray, wfull, walmost_full, wlevel, wovf});
      end
      @(negedge wclk);
      wrst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 5'd0);
         e = q.pop_front();
         tests++;
         if ({waddr, wgray, wfull, walmost_full, wlevel, wovf} !==
             {e.waddr, e.wgray, e.wfull, e.waf, e.wlevel, e.wovf}) begin
            fails++;
            $display("FAIL idle_%0d: got %h want %h", i,
                     {waddr, wgray, wfull, walmost_full, wlevel, wovf},
                     {e.waddr, e.wgray, e.wfull, e.waf, e.wlevel, e.wovf});
         end
      end
   endtask

   task automatic test_fill();
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 5'd0);
         e = q.pop_front();
         tests++;
         if (wgray !== e.wgray) begin
            fails++;
            $display("FAIL fill_wgray_%0d: got %b want %b", i, wgray, e.wgray);
         end
         tests++;
         if (waddr !== e.waddr) begin
            fails++;
            $display("FAIL fill_waddr_%0d: got %h want %h", i, waddr, e.waddr);
         end
         tests++;
         if (wlevel !== e.wlevel) begin
            fails++;
            $display("FAIL fill_wlevel_%0d: got %0d want %0d", i, wlevel, e.wlevel);
         end
         tests++;
         if ({wfull, walmost_full, wovf} !== {e.wfull, e.waf, e.wovf}) begin
            fails++;
            $display("FAIL fill_flags_%0d: got %b want %b", i, {wfull, walmost_full, wovf},
                     {e.wfull, e.waf, e.wovf});
         end
      end
      tests++;
      if ({wgray, wfull, wlevel} !== {5'b11000, 1'b1, 5'd16}) begin
         fails++;
         $display("FAIL fill_final: got gray=%b full=%b lvl=%0d want gray=11000 full=1 lvl=16",
                  wgray, wfull, wlevel);
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'd0);
         e = q.pop_front();
         tests++;
         if ({wovf, wgray, wlevel, wfull} !== {e.wovf, e.wgray, e.wlevel, e.wfull}) begin
            fails++;
            $display("FAIL ovf_%0d: got ovf=%b gray=%b lvl=%0d full=%b want ovf=%b gray=%b lvl=%0d full=%b",
                     i, wovf, wgray, wlevel, wfull, e.wovf, e.wgray, e.wlevel, e.wfull);
         end
      end
      drive(1'b0, 5'd0);
      e = q.pop_front();
      tests++;
      if ({wovf, wgray} !== {e.wovf, e.wgray}) begin
         fails++;
         $display("FAIL ovf_clear: got ovf=%b gray=%b want ovf=%b gray=%b", wovf, wgray, e.wovf, e.wgray);
      end
   endtask

   task automatic test_read_free();
      exp_t e;
      drive(1'b0, 5'd1);
      e = q.pop_front();
      tests++;
      if ({wfull, wlevel, walmost_full} !== {e.wfull, e.wlevel, e.waf} || wlevel !== 5'd15) begin
         fails++;
         $display("FAIL read_free: got full=%b lvl=%0d af=%b want full=%b lvl=%0d af=%b",
                  wfull, wlevel, walmost_full, e.wfull, e.wlevel, e.waf);
      end
      drive(1'b1, 5'd1);
      e = q.pop_front();
      tests++;
      if ({wfull, wgray, wlevel} !== {e.wfull, e.wgray, e.wlevel} || wgray !== 5'b11001) begin
         fails++;
         $display("FAIL refill: got full=%b gray=%b lvl=%0d want full=%b gray=%b lvl=%0d",
                  wfull, wgray, wlevel, e.wfull, e.wgray, e.wlevel);
      end
   endtask

   task automatic test_wrap();
      exp_t       e;
      logic [4:0] rb;
      logic [4:0] prev;
      rb = 5'd14;
      drive(1'b0, rb);
      e = q.pop_front();
      tests++;
      if ({wlevel, wfull} !== {e.wlevel, e.wfull}) begin
         fails++;
         $display("FAIL wrap_setup: got lvl=%0d full=%b want lvl=%0d full=%b", wlevel, wfull, e.wlevel, e.wfull);
      end
      for (int i = 0; i < 40; i++) begin
         prev = wgray;
         rb   = rb + 5'd1;
         drive(1'b1, rb);
         e = q.pop_front();
         tests++;
         if ($countones(prev ^ wgray) != 1 || wgray !== e.wgray) begin
            fails++;
            $display("FAIL wrap_gray_%0d: got %b (prev %b) want %b", i, wgray, prev, e.wgray);
         end
         tests++;
         if ({wlevel, wfull, walmost_full, wovf} !== {e.wlevel, e.wfull, e.waf, e.wovf}) begin
            fails++;
            $display("FAIL wrap_status_%0d: got lvl=%0d full=%b af=%b ovf=%b want lvl=%0d full=%b af=%b ovf=%b",
                     i, wlevel, wfull, walmost_full, wovf, e.wlevel, e.wfull, e.waf, e.wovf);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      apply_reset();
      @(negedge wclk);
      wrst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 5'd0);
         e = q.pop_front();
      end
      tests++;
      if (wlevel !== e.wlevel) begin
         fails++;
         $display("FAIL mid_level: got %0d want %0d", wlevel, e.wlevel);
      end
      #2;
      apply_reset();
      #1;
      tests++;
      if ({waddr, wgray, wfull, walmost_full, wlevel, wovf} !== 17'd0) begin
         fails++;
         $display("FAIL mid_async_reset: got %h want 0", {waddr, wgray, wfull, walmost_full, wlevel, wovf});
      end
      @(negedge wclk);
      wrst_n = 1'b1;
      drive(1'b1, 5'd0);
      e = q.pop_front();
      tests++;
      if ({waddr, wgray} !== {e.waddr, e.wgray} || {waddr, wgray} !== {4'd1, 5'b00001}) begin
         fails++;
         $display("FAIL post_reset_push: got addr=%0d gray=%b want addr=%0d gray=%b",
                  waddr, wgray, e.waddr, e.wgray);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_read_free();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
